bg_pixel_fetcher: RTL and testbench

Background/window pixel fetcher on the read side of the 8 KB video RAM. It walks one scanline of tiles, reads the tile-map index and the two tile-data bitplanes through one combinational-read VRAM port, and expands each tile row into eight 2-bit colour indices. Those indices go into a 16-entry pixel FIFO, which drains to the LCD/palette stage through a valid/ready handshake, 160 pixels per line.

---
 rtl/bg_pixel_fetcher.sv | 218 +++++++++++++++++++++
 tb/tb_bg_pixel_fetcher.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_pixel_fetcher.sv
// Background/window tile fetcher: walks one scanline of tiles through a combinational VRAM
// port and feeds a 16-entry 2-bit pixel FIFO. Window support is compiled in with BG_WINDOW_EN.
//
// state | meaning
// IDLE  | no line in progress, VRAM address parked at 0
// MAP   | read tile-map index
// LO    | read low bitplane byte of the tile row
// HI    | read high bitplane byte of the tile row
// PUSH  | write 8 pixels once the FIFO holds 8 or fewer
module bg_pixel_fetcher (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        line_start_i,
    input  logic [7:0]  ly_i,
    input  logic [7:0]  scx_i,
    input  logic [7:0]  scy_i,
    input  logic        bg_map_sel_i,
    input  logic        tile_data_sel_i,
    input  logic        win_en_i,
    input  logic        win_map_sel_i,
    input  logic [7:0]  wx_i,
    input  logic [7:0]  wy_i,
    output logic [12:0] vram_addr_o,
    input  logic [7:0]  vram_data_i,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic [1:0]  pix_data_o,
    output logic        busy_o,
    output logic        line_done_o
);
    typedef enum logic [2:0] {S_IDLE, S_MAP, S_LO, S_HI, S_PUSH} state_t;

    state_t      state_q, state_d;
    logic [4:0]  tile_x_q, tile_x_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  x_q, x_d;
    logic [2:0]  discard_q, discard_d;
    logic        done_q, done_d;
    logic        win_mode_q, win_mode_d;
    logic        win_seen_q, win_seen_d;

    logic [1:0]  fifo_q [16];
    logic [3:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  wr_ptr_q, wr_ptr_d;
    logic [4:0]  count_q, count_d;

    logic [7:0]  row_y;
    logic [7:0]  fetch_y;
    logic [4:0]  map_col;
    logic [12:0] map_base;
    logic [12:0] tile_base;
    logic [12:0] row_off;
    logic        win_trig;
    logic        pop_ext;
    logic        pop_int;
    logic        push;

    assign busy_o = (state_q != S_IDLE);

`ifdef BG_WINDOW_EN
    logic [7:0] win_x;
    assign win_x    = (wx_i < 8'd7) ? 8'd0 : wx_i - 8'd7;
    assign win_trig = busy_o && win_en_i && !win_seen_q && (ly_i >= wy_i) && (x_q == win_x);
`else
    logic unused_win;
    assign unused_win = ^{win_en_i, wx_i};
    assign win_trig   = 1'b0;
`endif

    // In window mode the row comes from ly-wy and the column from tile_x alone.
    assign row_y     = ly_i + scy_i;
    assign fetch_y   = win_mode_q ? (ly_i - wy_i) : row_y;
    assign map_col   = win_mode_q ? tile_x_q : (scx_i[7:3] + tile_x_q);
    assign map_base  = (win_mode_q ? win_map_sel_i : bg_map_sel_i) ? 13'h1C00 : 13'h1800;
    assign tile_base = tile_data_sel_i ? {1'b0, idx_q, 4'b0000}
                                       : 13'h1000 + {idx_q[7], idx_q, 4'b0000};
    assign row_off   = {9'd0, fetch_y[2:0], 1'b0};

    assign pix_valid_o = busy_o && (count_q != 5'd0) && (discard_q == 3'd0) && !win_trig;
    assign pix_data_o  = pix_valid_o ? fifo_q[rd_ptr_q] : 2'b00;
    assign pop_ext     = pix_valid_o && pix_ready_i;
    assign pop_int     = busy_o && (discard_q != 3'd0) && (count_q != 5'd0);
    assign push        = (state_q == S_PUSH) && (count_q <= 5'd8);
    assign line_done_o = done_q;

    always_comb begin
        vram_addr_o = 13'd0;
        case (state_q)
            S_MAP:   vram_addr_o = map_base + {3'b000, fetch_y[7:3], map_col};
            S_LO:    vram_addr_o = tile_base + row_off;
            S_HI:    vram_addr_o = tile_base + row_off + 13'd1;
            default: vram_addr_o = 13'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        tile_x_d   = tile_x_q;
        idx_d      = idx_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        x_d        = x_q;
        discard_d  = discard_q;
        done_d     = 1'b0;
        win_mode_d = win_mode_q;
        win_seen_d = win_seen_q;
        rd_ptr_d   = rd_ptr_q + ((pop_ext || pop_int) ? 4'd1 : 4'd0);
        wr_ptr_d   = wr_ptr_q + (push ? 4'd8 : 4'd0);
        count_d    = count_q + (push ? 5'd8 : 5'd0) - ((pop_ext || pop_int) ? 5'd1 : 5'd0);

        case (state_q)
            S_MAP: begin
                idx_d   = vram_data_i;
                state_d = S_LO;
            end
            S_LO: begin
                lo_d    = vram_data_i;
                state_d = S_HI;
            end
            S_HI: begin
                hi_d    = vram_data_i;
                state_d = S_PUSH;
            end
            S_PUSH: begin
                if (push) begin
                    tile_x_d = tile_x_q + 5'd1;
                    state_d  = S_MAP;
                end
            end
            default: ;
        endcase

        if (pop_int) begin
            discard_d = discard_q - 3'd1;
        end

        if (pop_ext) begin
            if (x_q == 8'd159) begin
                state_d  = S_IDLE;
                x_d      = 8'd0;
                rd_ptr_d = 4'd0;
                wr_ptr_d = 4'd0;
                count_d  = 5'd0;
                done_d   = 1'b1;
            end else begin
                x_d = x_q + 8'd1;
            end
        end

        if (win_trig) begin
            state_d    = S_MAP;
            tile_x_d   = 5'd0;
            discard_d  = 3'd0;
            rd_ptr_d   = 4'd0;
            wr_ptr_d   = 4'd0;
            count_d    = 5'd0;
            win_mode_d = 1'b1;
            win_seen_d = 1'b1;
        end

        // A new line overrides everything else happening this cycle.
        if (line_start_i) begin
            state_d    = S_MAP;
            tile_x_d   = 5'd0;
            x_d        = 8'd0;
            discard_d  = scx_i[2:0];
            rd_ptr_d   = 4'd0;
            wr_ptr_d   = 4'd0;
            count_d    = 5'd0;
            done_d     = 1'b0;
            win_mode_d = 1'b0;
            win_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            tile_x_q   <= 5'd0;
            idx_q      <= 8'd0;
            lo_q       <= 8'd0;
            hi_q       <= 8'd0;
            x_q        <= 8'd0;
            discard_q  <= 3'd0;
            done_q     <= 1'b0;
            win_mode_q <= 1'b0;
            win_seen_q <= 1'b0;
            rd_ptr_q   <= 4'd0;
            wr_ptr_q   <= 4'd0;
            count_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            tile_x_q   <= tile_x_d;
            idx_q      <= idx_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            x_q        <= x_d;
            discard_q  <= discard_d;
            done_q     <= done_d;
            win_mode_q <= win_mode_d;
            win_seen_q <= win_seen_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Leftmost pixel (bit 7) lands at the current write pointer.
    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int i = 0; i < 8; i++) begin
                fifo_q[wr_ptr_q + 4'(i)] <= {hi_q[3'(7 - i)], lo_q[3'(7 - i)]};
            end
        end
    end
endmodule

// File: tb/tb_bg_pixel_fetcher.sv
// Self-checking bench for bg_pixel_fetcher: directed address/timing cases plus random lines
// with random backpressure, checked against a per-pixel screen-coordinate model.
module tb_bg_pixel_fetcher;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [7:0]  ly = 8'd0, scx = 8'd0, scy = 8'd0;
    logic        bg_map_sel = 1'b0, tile_data_sel = 1'b1;
    logic        win_en = 1'b0, win_map_sel = 1'b0;
    logic [7:0]  wx = 8'd0, wy = 8'd0;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [1:0]  pix_data;
    logic        busy;
    logic        line_done;

    logic [7:0]  vram [0:8191];
    logic [1:0]  exp_pix [160];
    bit          rand_ready = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    assign vram_data = vram[vram_addr];

    bg_pixel_fetcher dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .line_start_i   (line_start),
        .ly_i           (ly),
        .scx_i          (scx),
        .scy_i          (scy),
        .bg_map_sel_i   (bg_map_sel),
        .tile_data_sel_i(tile_data_sel),
        .win_en_i       (win_en),
        .win_map_sel_i  (win_map_sel),
        .wx_i           (wx),
        .wy_i           (wy),
        .vram_addr_o    (vram_addr),
        .vram_data_i    (vram_data),
        .pix_valid_o    (pix_valid),
        .pix_ready_i    (pix_ready),
        .pix_data_o     (pix_data),
        .busy_o         (busy),
        .line_done_o    (line_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pixel of an 8x8 tile selected through a map entry.
    function automatic logic [1:0] tile_pix(input int map_a, input int row, input int b);
        int         idx, base;
        logic [7:0] lo, hi;
        idx = int'(vram[map_a]);
        if (tile_data_sel) base = idx * 16;
        else base = (4096 + ((idx >= 128) ? idx - 256 : idx) * 16) & 8191;
        lo = vram[base + 2 * row];
        hi = vram[base + 2 * row + 1];
        return {hi[7 - b], lo[7 - b]};
    endfunction

    // Expected line in screen coordinates: background pixel (scx+x, ly+scy) wrapped to 256x256.
    task automatic compute_exp();
        int xx, yy, mb;
        for (int x = 0; x < 160; x++) begin
            yy = (int'(ly) + int'(scy)) % 256;
            xx = (int'(scx) + x) % 256;
            mb = bg_map_sel ? 'h1C00 : 'h1800;
            exp_pix[x] = tile_pix(mb + (yy / 8) * 32 + xx / 8, yy % 8, xx % 8);
`ifdef BG_WINDOW_EN
            begin
                int wxs, c, yw;
                wxs = (wx < 7) ? 0 : int'(wx) - 7;
                if (win_en && ly >= wy && x >= wxs) begin
                    c  = x - wxs;
                    yw = int'(ly) - int'(wy);
                    mb = win_map_sel ? 'h1C00 : 'h1800;
                    exp_pix[x] = tile_pix(mb + (yw / 8) * 32 + (c / 8) % 32, yw % 8, c % 8);
                end
            end
`endif
        end
    endtask

    always @(posedge clk) begin
        #1;
        pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    int         cx = 0;
    bit         in_line = 1'b0;
    bit         exp_done = 1'b0;
    bit         prev_stall = 1'b0;
    logic [1:0] prev_data = 2'b00;

    always @(negedge clk) begin
        if (reset) begin
            cx = 0;
            in_line = 1'b0;
            exp_done = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("line_done", int'(line_done), int'(exp_done));
            if (exp_done) check("busy_after_done", int'(busy), 0);
            exp_done = 1'b0;
            if (prev_stall) begin
                check("stall_valid", int'(pix_valid), 1);
                check("stall_data", int'(pix_data), int'(prev_data));
            end
            prev_stall = 1'b0;
            if (line_start) begin
                cx = 0;
                in_line = 1'b1;
            end else if (!in_line) begin
                check("valid_idle", int'(pix_valid), 0);
            end else if (pix_valid) begin
                if (pix_ready) begin
                    check($sformatf("pix%0d", cx), int'(pix_data), int'(exp_pix[cx]));
                    cx++;
                    if (cx == 160) begin
                        exp_done = 1'b1;
                        in_line = 1'b0;
                    end
                end else begin
                    prev_stall = 1'b1;
                    prev_data = pix_data;
                end
            end
        end
    end

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            tick();
            seen = line_done;
        end
        if (!seen) check("line_done_timeout", int'(seen), 1);
        tick();
    endtask

    task automatic start_line();
        compute_exp();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic directed(input int map_a, input int lo_a, input int first_k);
        int k;
        start_line();
        @(negedge clk);
        check("busy_rise", int'(busy), 1);
        check("map_addr", int'(vram_addr), map_a);
        @(negedge clk);
        check("lo_addr", int'(vram_addr), lo_a);
        @(negedge clk);
        check("hi_addr", int'(vram_addr), lo_a + 1);
        k = 3;
        while (!pix_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("first_valid_cycle", k, first_k);
        wait_done();
    endtask

    task automatic rand_cfg();
        ly            = 8'($urandom_range(0, 143));
        scx           = 8'($urandom);
        scy           = 8'($urandom);
        bg_map_sel    = 1'($urandom);
        tile_data_sel = 1'($urandom);
        win_en        = 1'($urandom);
        win_map_sel   = 1'($urandom);
        wx            = 8'($urandom_range(0, 175));
        wy            = 8'($urandom_range(0, 150));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit [8];
        lit = '{3, 3, 1, 1, 2, 2, 0, 0};
        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);

        repeat (3) tick();
        line_start = 1'b1;
        tick();
        reset = 1'b0;
        line_start = 1'b0;
        @(negedge clk);
        check("rst_vram_addr", int'(vram_addr), 0);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_pix_data", int'(pix_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_line_done", int'(line_done), 0);
        tick();
        tick();
        @(negedge clk);
        check("rst_stays_idle", int'(busy), 0);
        tick();

        // Basic tile: index 1, rows 0xF0/0xCC.
        win_en = 1'b0; ly = 8'd0; scx = 8'd0; scy = 8'd0; bg_map_sel = 1'b0; tile_data_sel = 1'b1;
        vram['h1800] = 8'h01; vram['h0010] = 8'hF0; vram['h0011] = 8'hCC;
        compute_exp();
        for (int i = 0; i < 8; i++) check($sformatf("model_pin%0d", i), int'(exp_pix[i]), lit[i]);
        directed('h1800, 'h0010, 5);

        // Signed tile data: index 0x80 at row 2, then 0x7F at row 0.
        tile_data_sel = 1'b0; ly = 8'd2;
        vram['h1800] = 8'h80;
        directed('h1800, 'h0804, 5);
        ly = 8'd0;
        vram['h1800] = 8'h7F;
        directed('h1800, 'h17F0, 5);

        // Scroll with fine discard.
        tile_data_sel = 1'b1; scx = 8'h05; scy = 8'h0B; ly = 8'd3;
        vram['h1820] = 8'h02;
        directed('h1820, 'h002C, 10);

        // Map column wrap 31 -> 0.
        scx = 8'hFB; scy = 8'd0; ly = 8'd0;
        vram['h181F] = 8'h04;
        directed('h181F, 'h0040, 8);

`ifdef BG_WINDOW_EN
        scx = 8'd0; scy = 8'd0; ly = 8'd0; bg_map_sel = 1'b0; tile_data_sel = 1'b1;
        win_en = 1'b1; win_map_sel = 1'b1; wx = 8'd87; wy = 8'd0;
        vram['h1C00] = 8'h03; vram['h0030] = 8'hFF; vram['h0031] = 8'h00;
        compute_exp();
        for (int i = 80; i < 88; i++) check($sformatf("win_pin%0d", i), int'(exp_pix[i]), 1);
        start_line();
        wait_done();
`endif

        rand_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            rand_cfg();
            start_line();
            wait_done();
        end

        // Restart mid-line.
        for (int n = 0; n < 3; n++) begin
            rand_cfg();
            start_line();
            repeat (40 + 30 * n) tick();
            rand_cfg();
            start_line();
            wait_done();
        end

        rand_ready = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
